// File: rtl/rtc_bus_arbiter.sv
// RTC DatAdd bus arbiter: writes (priority) and a refresh read scan share one multiplexed bus.
// Each bus cycle is 4*T_PH clocks plus one IDLE clock; requesters hold wr_req until wr_ack, with no preemption.
module rtc_bus_arbiter #(
  parameter int          T_PH       = 10,
  parameter logic [7:0]  SCAN_FIRST = 8'h21,
  parameter logic [7:0]  SCAN_LAST  = 8'h26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  input  logic       scan_en,
  output logic       rf_we,
  output logic [3:0] rf_addr,
  output logic [7:0] rf_data,
  output logic       CS,
  output logic       AD,
  output logic       RD,
  output logic       WR,
  output logic [7:0] dat_out,
  output logic       dat_oe,
  input  logic [7:0] dat_in,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_LATCH = 3'd2,
    S_DATA  = 3'd3,
    S_GAP   = 3'd4
  } st_t;

  localparam logic [7:0] PH_LOAD = 8'(T_PH - 1);

  st_t        st_q, st_d;
  logic [7:0] ph_q;
  logic       cyc_wr_q;
  logic [7:0] cyc_addr_q;
  logic [7:0] cyc_data_q;
  logic [7:0] ptr_q;
  logic       ph_done;
  logic       grant_wr;
  logic       grant_rd;
  logic       rd_done;
  logic       wr_done;

  assign ph_done = (ph_q == 8'd0);
  assign rd_done = (st_q == S_DATA) && ph_done && !cyc_wr_q;
  assign wr_done = (st_q == S_GAP) && ph_done && cyc_wr_q;

  always_comb begin
    st_d     = st_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    case (st_q)
      S_IDLE: begin
        // a request still high while its own ack is showing is the one just served
        if (wr_req && !wr_ack) begin
          st_d     = S_ADDR;
          grant_wr = 1'b1;
        end else if (scan_en) begin
          st_d     = S_ADDR;
          grant_rd = 1'b1;
        end
      end
      S_ADDR:  if (ph_done) st_d = S_LATCH;
      S_LATCH: if (ph_done) st_d = S_DATA;
      S_DATA:  if (ph_done) st_d = S_GAP;
      S_GAP:   if (ph_done) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_comb begin
    CS      = 1'b1;
    AD      = 1'b1;
    RD      = 1'b1;
    WR      = 1'b1;
    dat_oe  = 1'b0;
    dat_out = 8'h00;
    case (st_q)
      S_ADDR: begin
        CS      = 1'b0;
        AD      = 1'b0;
        WR      = 1'b0;
        dat_oe  = 1'b1;
        dat_out = cyc_addr_q;
      end
      S_LATCH: begin
        CS      = 1'b0;
        dat_oe  = 1'b1;
        dat_out = cyc_addr_q;
      end
      S_DATA: begin
        CS = 1'b0;
        if (cyc_wr_q) begin
          WR      = 1'b0;
          dat_oe  = 1'b1;
          dat_out = cyc_data_q;
        end else begin
          RD = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q       <= S_IDLE;
      ph_q       <= 8'd0;
      cyc_wr_q   <= 1'b0;
      cyc_addr_q <= 8'h00;
      cyc_data_q <= 8'h00;
      ptr_q      <= SCAN_FIRST;
      wr_ack     <= 1'b0;
      rf_we      <= 1'b0;
      rf_addr    <= 4'd0;
      rf_data    <= 8'h00;
    end else begin
      st_q <= st_d;
      if (st_d != st_q) begin
        ph_q <= (st_d == S_IDLE) ? 8'd0 : PH_LOAD;
      end else if (!ph_done) begin
        ph_q <= ph_q - 8'd1;
      end
      if (grant_wr) begin
        cyc_wr_q   <= 1'b1;
        cyc_addr_q <= wr_addr;
        cyc_data_q <= wr_data;
      end else if (grant_rd) begin
        cyc_wr_q   <= 1'b0;
        cyc_addr_q <= ptr_q;
      end
      // both strobes are registered so they rise on the edge of the transition they mark
      wr_ack <= wr_done;
      rf_we  <= rd_done;
      if (rd_done) begin
        rf_addr <= cyc_addr_q[3:0] - SCAN_FIRST[3:0];
        rf_data <= dat_in;
        ptr_q   <= (cyc_addr_q == SCAN_LAST) ? SCAN_FIRST : cyc_addr_q + 8'd1;
      end
    end
  end

  assign busy  = (st_q != S_IDLE);
  assign state = st_q;

endmodule
